// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the receiver and the transmitter:
//   - uart_state_e : frame-level FSM encoding (IDLE, START, DATA, PARITY, STOP)
//   - default frame / timing constants
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int UART_DATA_WIDTH     = 8;
    localparam int UART_CLOCKS_PER_BIT = 8;
    localparam int UART_SYNC_STAGES    = 3;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Multi-flop synchronizer for the asynchronous serial line. All stages reset
// to 1 so that an idle (high) line never looks like a falling edge after reset.
// Ports:
//   clk      in  1  rising-edge clock
//   reset    in  1  synchronous, active-high
//   async_in in  1  asynchronous input
//   sync_out out 1  last synchronizer stage
// -----------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int STAGES = UART_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_d[gi] = async_in;
            end else begin : g_chain
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start bit, DATA_WIDTH data bits (LSB first), optional even
// parity bit, 1 stop bit. Oversampled at CLOCKS_PER_BIT clocks per bit.
//
// Build option: define UART_RX_PARITY_EN to add the parity bit to the frame
// and report parity errors on rx_error. Without it the frame has no parity
// bit and rx_error reports framing errors only.
//
// Ports:
//   clk           in  1           rising-edge clock
//   reset         in  1           synchronous, active-high
//   serial_in     in  1           asynchronous serial line, idles high
//   received_data out DATA_WIDTH  last frame received without error
//   data_is_valid out 1           one-cycle pulse per good frame
//   rx_error      out 1           one-cycle pulse per parity/framing error
//   busy          out 1           FSM not in IDLE
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT,
    parameter int SYNC_STAGES    = UART_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] received_data,
    output logic                  data_is_valid,
    output logic                  rx_error,
    output logic                  busy
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Start bit is sampled mid-bit; every later sample is a full bit period on.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    logic line;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (serial_in),
        .sync_out (line)
    );

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] received_data_q, received_data_d;
    logic                  line_prev_q, line_prev_d;
    logic                  done_q, done_d;
    logic                  ok_q, ok_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
`ifdef UART_RX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic bit_tick;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q + 1'b1;
        idx_d           = idx_q;
        shift_d         = shift_q;
        received_data_d = received_data_q;
        line_prev_d     = line;
        done_d          = 1'b0;
        ok_d            = ok_q;
        valid_d         = 1'b0;
        err_d           = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_d        = parity_q;
`endif

        bit_tick = (state_q == START) ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);

        // Outputs are issued one cycle after the stop sample, from the
        // verdict latched at that sample.
        if (done_q) begin
            valid_d = ok_q;
            err_d   = ~ok_q;
            if (ok_q) begin
                received_data_d = shift_q;
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                // Edge (not level) detect: a line held low after a break
                // must go high again before a new start is recognised.
                if (line_prev_q && !line) begin
                    state_d = START;
                end
            end

            START: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (line) begin
                        state_d = IDLE;   // glitch, not a real start bit
                    end else begin
                        state_d = DATA;
`ifdef UART_RX_PARITY_EN
                        parity_d = 1'b0;
`endif
                    end
                end
            end

            DATA: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    // Shift in from the top: after DATA_WIDTH samples the
                    // first (LSB) bit has reached bit 0.
                    shift_d = {line, shift_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_PARITY_EN
                    parity_d = parity_q ^ line;
`endif
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    cnt_d    = '0;
                    parity_d = parity_q ^ line;
                    state_d  = STOP;
                end
            end
`endif

            STOP: begin
                if (bit_tick) begin
                    // Leave mid stop bit so a start bit that follows
                    // immediately is still caught as an edge.
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                    ok_d = line & ~parity_q;
`else
                    ok_d = line;
`endif
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            shift_q         <= '0;
            received_data_q <= '0;
            line_prev_q     <= 1'b1;
            done_q          <= 1'b0;
            ok_q            <= 1'b0;
            valid_q         <= 1'b0;
            err_q           <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            shift_q         <= shift_d;
            received_data_q <= received_data_d;
            line_prev_q     <= line_prev_d;
            done_q          <= done_d;
            ok_q            <= ok_d;
            valid_q         <= valid_d;
            err_q           <= err_d;
`ifdef UART_RX_PARITY_EN
            parity_q        <= parity_d;
`endif
        end
    end

    assign received_data = received_data_q;
    assign data_is_valid = valid_q;
    assign rx_error      = err_q;
    assign busy          = (state_q != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed, self-checking bench for uart_rx at default parameters
// (8 data bits, 8 clk/bit, 3 sync stages). Adapts frame length and latency to
// whether UART_RX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam int LAT       = 88;   // first low sample -> data_is_valid
    localparam int FRAME_CYC = 88;   // 11 bits x 8 clk
`else
    localparam int LAT       = 80;
    localparam int FRAME_CYC = 80;   // 10 bits x 8 clk
`endif
    localparam int CPB = 8;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic [7:0] received_data;
    logic       data_is_valid;
    logic       rx_error;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int frame_start_cyc = 0;
    int both_count = 0;

    int         valid_cyc[$];
    logic [7:0] valid_dat[$];
    int         err_cyc[$];

    uart_rx #(
        .DATA_WIDTH     (8),
        .CLOCKS_PER_BIT (8),
        .SYNC_STAGES    (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .received_data (received_data),
        .data_is_valid (data_is_valid),
        .rx_error      (rx_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (data_is_valid) begin
            valid_cyc.push_back(cyc);
            valid_dat.push_back(received_data);
            $display("[%0d] data_is_valid received_data=0x%02h", cyc, received_data);
        end
        if (rx_error) begin
            err_cyc.push_back(cyc);
            $display("[%0d] rx_error", cyc);
        end
        if (data_is_valid && rx_error) begin
            both_count = both_count + 1;
        end
    end

    task automatic clear_log();
        valid_cyc.delete();
        valid_dat.delete();
        err_cyc.delete();
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Called on a falling edge; the next rising edge is the first to see the
    // start bit, so that edge is recorded as the frame origin.
    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        frame_start_cyc = cyc + 1;
        $display("[%0d] send frame data=0x%02h par=%0b stop=%0b", cyc, d, par_bit, stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i]);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
        checks++;
        if (data_is_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b expected 0", data_is_valid); end
        checks++;
        if (rx_error !== 1'b0) begin errors++; $display("FAIL reset_err got %0b expected 0", rx_error); end
        checks++;
        if (received_data !== 8'h00) begin errors++; $display("FAIL reset_data got 0x%02h expected 0x00", received_data); end
        idle(4);
    endtask

    task automatic test_basic();
        int s;
        clear_log();
        send_frame(8'hA5, 1'b0, 1'b1);
        s = frame_start_cyc;
        idle(6);
        checks++;
        if (valid_cyc.size() !== 1) begin errors++; $display("FAIL basic_valid_count got %0d expected 1", valid_cyc.size()); end
        if (valid_cyc.size() >= 1) begin
            checks++;
            if (valid_cyc[0] !== s + LAT) begin errors++; $display("FAIL basic_latency got %0d expected %0d", valid_cyc[0] - s, LAT); end
            checks++;
            if (valid_dat[0] !== 8'hA5) begin errors++; $display("FAIL basic_data got 0x%02h expected 0xA5", valid_dat[0]); end
        end
        checks++;
        if (err_cyc.size() !== 0) begin errors++; $display("FAIL basic_err_count got %0d expected 0", err_cyc.size()); end
        checks++;
        if (received_data !== 8'hA5) begin errors++; $display("FAIL basic_hold got 0x%02h expected 0xA5", received_data); end
    endtask

    task automatic test_parity_error();
`ifdef UART_RX_PARITY_EN
        int s;
        clear_log();
        send_frame(8'h01, 1'b0, 1'b1);   // correct even parity would be 1
        s = frame_start_cyc;
        idle(6);
        checks++;
        if (err_cyc.size() !== 1) begin errors++; $display("FAIL parity_err_count got %0d expected 1", err_cyc.size()); end
        if (err_cyc.size() >= 1) begin
            checks++;
            if (err_cyc[0] !== s + LAT) begin errors++; $display("FAIL parity_err_latency got %0d expected %0d", err_cyc[0] - s, LAT); end
        end
        checks++;
        if (valid_cyc.size() !== 0) begin errors++; $display("FAIL parity_valid_count got %0d expected 0", valid_cyc.size()); end
        checks++;
        if (received_data !== 8'hA5) begin errors++; $display("FAIL parity_hold got 0x%02h expected 0xA5", received_data); end
`endif
    endtask

    task automatic test_break();
        int s;
        clear_log();
        send_frame(8'h3C, 1'b0, 1'b0);
        s = frame_start_cyc;
        serial_in = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (err_cyc.size() !== 1) begin errors++; $display("FAIL break_err_count got %0d expected 1", err_cyc.size()); end
        if (err_cyc.size() >= 1) begin
            checks++;
            if (err_cyc[0] !== s + LAT) begin errors++; $display("FAIL break_err_latency got %0d expected %0d", err_cyc[0] - s, LAT); end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL break_busy got %0b expected 0", busy); end
        checks++;
        if (received_data !== 8'hA5) begin errors++; $display("FAIL break_hold got 0x%02h expected 0xA5", received_data); end
        idle(8);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(6);
        checks++;
        if (valid_cyc.size() !== 1) begin errors++; $display("FAIL break_valid_count got %0d expected 1", valid_cyc.size()); end
        if (valid_dat.size() >= 1) begin
            checks++;
            if (valid_dat[0] !== 8'h5A) begin errors++; $display("FAIL break_data got 0x%02h expected 0x5A", valid_dat[0]); end
        end
        checks++;
        if (err_cyc.size() !== 1) begin errors++; $display("FAIL break_err_after got %0d expected 1", err_cyc.size()); end
    endtask

    task automatic test_glitch();
        clear_log();
        $display("[%0d] glitch 2 cycles", cyc);
        serial_in = 1'b0;
        repeat (2) @(negedge clk);
        serial_in = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got %0b expected 1", busy); end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop got %0b expected 0", busy); end
        idle(20);
        checks++;
        if (valid_cyc.size() + err_cyc.size() !== 0) begin
            errors++; $display("FAIL glitch_pulses got %0d expected 0", valid_cyc.size() + err_cyc.size());
        end
    endtask

    task automatic test_back_to_back();
        int s;
        clear_log();
        send_frame(8'hFF, 1'b0, 1'b1);
        s = frame_start_cyc;
        send_frame(8'h00, 1'b0, 1'b1);
        idle(6);
        checks++;
        if (valid_cyc.size() !== 2) begin errors++; $display("FAIL b2b_valid_count got %0d expected 2", valid_cyc.size()); end
        if (valid_cyc.size() >= 2) begin
            checks++;
            if (valid_cyc[0] !== s + LAT) begin errors++; $display("FAIL b2b_first_latency got %0d expected %0d", valid_cyc[0] - s, LAT); end
            checks++;
            if (valid_cyc[1] - valid_cyc[0] !== FRAME_CYC) begin
                errors++; $display("FAIL b2b_spacing got %0d expected %0d", valid_cyc[1] - valid_cyc[0], FRAME_CYC);
            end
            checks++;
            if (valid_dat[0] !== 8'hFF) begin errors++; $display("FAIL b2b_data0 got 0x%02h expected 0xFF", valid_dat[0]); end
            checks++;
            if (valid_dat[1] !== 8'h00) begin errors++; $display("FAIL b2b_data1 got 0x%02h expected 0x00", valid_dat[1]); end
        end
        checks++;
        if (err_cyc.size() !== 0) begin errors++; $display("FAIL b2b_err_count got %0d expected 0", err_cyc.size()); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int s;
        clear_log();
        d = 8'h77;
        $display("[%0d] partial frame 0x77, reset after 40 cycles", cyc);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_bit(d[i]);
        end
        reset     = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b expected 0", busy); end
        checks++;
        if (received_data !== 8'h00) begin errors++; $display("FAIL midreset_data got 0x%02h expected 0x00", received_data); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle got %0b expected 0", busy); end
        idle(20);
        checks++;
        if (valid_cyc.size() + err_cyc.size() !== 0) begin
            errors++; $display("FAIL midreset_pulses got %0d expected 0", valid_cyc.size() + err_cyc.size());
        end
        send_frame(8'h12, 1'b0, 1'b1);
        s = frame_start_cyc;
        idle(6);
        checks++;
        if (valid_cyc.size() !== 1) begin errors++; $display("FAIL midreset_valid_count got %0d expected 1", valid_cyc.size()); end
        if (valid_cyc.size() >= 1) begin
            checks++;
            if (valid_dat[0] !== 8'h12) begin errors++; $display("FAIL midreset_next_data got 0x%02h expected 0x12", valid_dat[0]); end
            checks++;
            if (valid_cyc[0] !== s + LAT) begin errors++; $display("FAIL midreset_latency got %0d expected %0d", valid_cyc[0] - s, LAT); end
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_count !== 0) begin errors++; $display("FAIL valid_err_overlap got %0d expected 0", both_count); end
    endtask

    initial begin
        reset     = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity_error();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx
